// File: rtl/maxpool_relu_22_layer2.sv
// maxpool_relu_22_layer2
// Streaming ReLU + requantization + 2x2/stride-2 max-pool behind the layer-2
// 5x5 convolution. Consumes one raster-ordered output channel at a time and
// sequences the convolution across CO channels by pulsing o_self_rst when a
// channel's last pooled value leaves.
//
// Ports
//   clk           clock
//   global_rst_n  asynchronous active-low reset
//   user_reset    synchronous soft reset, same effect as global_rst_n
//   i_data        signed convolution accumulator (I_BW bits)
//   i_valid       single-cycle qualifier for i_data
//   i_conv_end    convolution reports end of its current channel
//   o_data        pooled activation (O_BW bits, always >= 0)
//   o_valid       1-cycle pulse qualifying o_data
//   o_ch_idx      index of the channel currently being pooled
//   o_ch_end      1-cycle pulse with the channel's final pooled value
//   o_self_rst    1-cycle pulse to the convolution, coincident with o_ch_end
//   o_all_end     high once all CO channels are done
//   o_err         sticky: i_conv_end arrived before the channel completed
//
// States
//   state    | meaning
//   ---------+----------------------------------------------------------
//   S_RUN    | accepting samples, pooling the current channel
//   S_CH_END | one cycle: channel finished, pulse end/self-reset, bump index
//   S_DONE   | all CO channels pooled; inputs ignored until reset

module maxpool_relu_22_layer2 #(
   parameter int I_BW    = 20,
   parameter int O_BW    = 8,
   parameter int IN_SIZE = 8,
   parameter int SHIFT   = 4,
   parameter int CO      = 4
) (
   input  logic                    clk,
   input  logic                    global_rst_n,
   input  logic                    user_reset,
   input  logic signed [I_BW-1:0]  i_data,
   input  logic                    i_valid,
   input  logic                    i_conv_end,
   output logic signed [O_BW-1:0]  o_data,
   output logic                    o_valid,
   output logic [$clog2(CO):0]     o_ch_idx,
   output logic                    o_ch_end,
   output logic                    o_self_rst,
   output logic                    o_all_end,
   output logic                    o_err
);

   localparam int CW   = $clog2(CO) + 1;
   // Position counters need at least 2 bits so the pair address slice exists.
   localparam int PW   = (IN_SIZE > 2) ? $clog2(IN_SIZE) : 2;
   localparam int LB_D = IN_SIZE / 2;

   localparam logic [PW-1:0]          POS_LAST = PW'(IN_SIZE - 1);
   localparam logic [CW-1:0]          CH_LAST  = CW'(CO - 1);
   localparam logic signed [I_BW-1:0] SAT_WIDE = I_BW'((2 ** (O_BW - 1)) - 1);
   localparam logic signed [O_BW-1:0] SAT_MAX  = O_BW'((2 ** (O_BW - 1)) - 1);

   typedef enum logic [1:0] {
      S_RUN    = 2'd0,
      S_CH_END = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic signed [O_BW-1:0]  s1_q, s1_d;
   logic                    s1_valid_q, s1_valid_d;
   logic [PW-1:0]           col_q, col_d;
   logic [PW-1:0]           row_q, row_d;
   logic signed [O_BW-1:0]  h_q, h_d;
   logic signed [O_BW-1:0]  o_data_q, o_data_d;
   logic                    o_valid_q, o_valid_d;
   logic [CW-1:0]           ch_idx_q, ch_idx_d;
   logic                    err_q, err_d;

   logic signed [O_BW-1:0]  lb [LB_D];
   logic [PW-2:0]           lb_addr;
   logic                    lb_we;
   logic signed [O_BW-1:0]  lb_rd;

   logic signed [I_BW-1:0]  shifted;
   logic signed [O_BW-1:0]  relu_sat;
   logic signed [O_BW-1:0]  hmax;
   logic signed [O_BW-1:0]  pool;
   logic                    accept;

   // ReLU first, then arithmetic shift, then clamp to the positive O_BW range.
   always_comb begin
      shifted = i_data >>> SHIFT;
      if (i_data[I_BW-1]) begin
         relu_sat = '0;
      end else if (shifted > SAT_WIDE) begin
         relu_sat = SAT_MAX;
      end else begin
         relu_sat = shifted[O_BW-1:0];
      end
   end

   assign accept  = i_valid && (state_q == S_RUN);
   assign lb_addr = col_q[PW-1:1];
   assign lb_rd   = lb[lb_addr];
   assign hmax    = (s1_q > h_q) ? s1_q : h_q;
   assign pool    = (lb_rd > hmax) ? lb_rd : hmax;

   always_comb begin
      state_d    = state_q;
      s1_d       = s1_q;
      s1_valid_d = 1'b0;
      col_d      = col_q;
      row_d      = row_q;
      h_d        = h_q;
      o_data_d   = o_data_q;
      o_valid_d  = 1'b0;
      ch_idx_d   = ch_idx_q;
      err_d      = err_q;
      lb_we      = 1'b0;

      if (accept) begin
         s1_d       = relu_sat;
         s1_valid_d = 1'b1;
      end

      case (state_q)
         S_RUN: begin
            if (i_conv_end && ((row_q != '0) || (col_q != '0))) begin
               err_d = 1'b1;
            end
            if (s1_valid_q) begin
               if (col_q == POS_LAST) begin
                  col_d = '0;
                  row_d = (row_q == POS_LAST) ? '0 : row_q + 1'b1;
               end else begin
                  col_d = col_q + 1'b1;
               end

               if (!col_q[0]) begin
                  h_d = s1_q;
               end else if (!row_q[0]) begin
                  lb_we = 1'b1;
               end else begin
                  o_data_d  = pool;
                  o_valid_d = 1'b1;
               end

               if ((row_q == POS_LAST) && (col_q == POS_LAST)) begin
                  state_d = S_CH_END;
               end
            end
         end

         S_CH_END: begin
            // A sample accepted in the last RUN cycle waits here and becomes
            // (0,0) of the next channel.
            s1_valid_d = s1_valid_q;
            row_d      = '0;
            col_d      = '0;
            h_d        = '0;
            ch_idx_d   = ch_idx_q + 1'b1;
            state_d    = (ch_idx_q == CH_LAST) ? S_DONE : S_RUN;
         end

         S_DONE: begin
         end

         default: begin
            state_d = S_RUN;
         end
      endcase
   end

   always_ff @(posedge clk or negedge global_rst_n) begin
      if (!global_rst_n) begin
         state_q    <= S_RUN;
         s1_q       <= '0;
         s1_valid_q <= 1'b0;
         col_q      <= '0;
         row_q      <= '0;
         h_q        <= '0;
         o_data_q   <= '0;
         o_valid_q  <= 1'b0;
         ch_idx_q   <= '0;
         err_q      <= 1'b0;
      end else if (user_reset) begin
         state_q    <= S_RUN;
         s1_q       <= '0;
         s1_valid_q <= 1'b0;
         col_q      <= '0;
         row_q      <= '0;
         h_q        <= '0;
         o_data_q   <= '0;
         o_valid_q  <= 1'b0;
         ch_idx_q   <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         s1_q       <= s1_d;
         s1_valid_q <= s1_valid_d;
         col_q      <= col_d;
         row_q      <= row_d;
         h_q        <= h_d;
         o_data_q   <= o_data_d;
         o_valid_q  <= o_valid_d;
         ch_idx_q   <= ch_idx_d;
         err_q      <= err_d;
      end
   end

   // Line buffer is never reset: every even row writes an entry before the
   // following odd row reads it.
   always_ff @(posedge clk) begin
      if (lb_we && !user_reset) begin
         lb[lb_addr] <= hmax;
      end
   end

   assign o_data     = o_data_q;
   assign o_valid    = o_valid_q;
   assign o_ch_idx   = ch_idx_q;
   assign o_ch_end   = (state_q == S_CH_END);
   assign o_self_rst = (state_q == S_CH_END);
   assign o_all_end  = (state_q == S_DONE);
   assign o_err      = err_q;

endmodule

// File: doc/maxpool_relu_22_layer2.md
# maxpool_relu_22_layer2

Streaming ReLU, requantization and 2×2/stride-2 max-pool stage that sits directly downstream of the layer-2 5×5 convolution. It consumes that block's raster-ordered accumulator stream (one output channel at a time) and emits O_BW-bit pooled activations for the next layer. It sequences the convolution across CO output channels: each time one channel finishes, it pulses `o_self_rst`, which advances the convolution's channel counter.

## Interface
- `I_BW`, 20, width of the signed convolution result
- `O_BW`, 8, width of the signed pooled output
- `IN_SIZE`, 8, convolution output feature-map width and height; must be even
- `SHIFT`, 4, arithmetic right shift applied for requantization
- `CO`, 4, number of output channels to process
- `clk`  in  1  clock
- `global_rst_n`  in  1  reset, asynchronous, active-low
- `user_reset`  in  1  synchronous soft reset; same effect as `global_rst_n`
- `i_data`  in  I_BW  signed convolution result
- `i_valid`  in  1  `i_data` valid (single-cycle qualifier)
- `i_conv_end`  in  1  convolution reports end of current channel
- `o_data`  out  O_BW  pooled activation
- `o_valid`  out  1  `o_data` valid, 1-cycle pulse
- `o_ch_idx`  out  clog2(CO)+1  index of the channel currently being pooled
- `o_ch_end`  out  1  1-cycle pulse when a channel's last pooled value is out
- `o_self_rst`  out  1  1-cycle pulse to the convolution block, coincident with `o_ch_end`
- `o_all_end`  out  1  high once all CO channels are done, until reset
- `o_err`  out  1  sticky: `i_conv_end` seen before the channel completed

## Operation
- **Stage 1 (registered).** Driven on `i_valid`.
  - If `i_data` is negative, `s1 = 0`.
  - Otherwise `s1 = i_data >>> SHIFT`, saturated to 2^(O_BW-1)-1.
  - `s1_valid` is `i_valid` delayed by one cycle.
- **Counters.** `col` and `row` each run 0..IN_SIZE-1 and advance on `s1_valid`. `col` wraps to 0 and increments `row`.
- **Horizontal pair.**
  - Even `col`: latch `h = s1`.
  - Odd `col`: `hmax = max(h, s1)`, computed combinationally.
- **Line buffer.** IN_SIZE/2 entries × O_BW, addressed `col>>1`.
  - Even `row`, odd `col`: write `hmax`.
  - Odd `row`, odd `col`: register `o_data = max(lb[col>>1], hmax)` and pulse `o_valid`.
  - Each channel produces (IN_SIZE/2)^2 outputs.
- **FSM states.**
  - RUN: accept input. On the `s1_valid` with `row = col = IN_SIZE-1`, go to CH_END.
  - CH_END (1 cycle): pulse `o_ch_end` and `o_self_rst`; increment `o_ch_idx`; clear `row`, `col` and `h`.
    - If `o_ch_idx + 1 == CO`, go to DONE.
    - Otherwise return to RUN.
  - DONE: `o_all_end = 1`; `i_valid` is ignored.
- **Input gating.** `i_valid` in CH_END or DONE is ignored, and the pipeline does not advance.
- **Error flag.** `i_conv_end = 1` in RUN with `row`/`col` not both zero sets `o_err`. The counters are not altered.
- **Widths.** All comparisons on the O_BW path are signed, but every value on that path is ≥ 0 after ReLU.

## Timing
- **Reset values.**
  - On `global_rst_n` low (async) or `user_reset` (sync): `o_data = 0`, `o_valid = 0`, `o_ch_idx = 0`, `o_ch_end = 0`, `o_self_rst = 0`, `o_all_end = 0`, `o_err = 0`.
  - State = RUN; counters, `h` and stage 1 are cleared. The line buffer is not cleared; it is always written before it is read.
- **Latency.** An `i_valid` sample at cycle t (odd row, odd col) produces `o_valid` at t+2.
- **Channel end.** `o_ch_end` occurs at t+2 for the last sample, in the same cycle as the channel's final `o_valid`.
- **Throughput.** Back-to-back `i_valid` every cycle is supported. Gaps of any length are tolerated; state is held.
- **Reset mid-channel.** `user_reset` at any cycle discards partial rows; the next sample is treated as (0,0) of channel 0.
- **Simultaneous events.** `user_reset` wins over `i_valid` and over the CH_END transition.

## Test plan
- **Ramp.** Set `i_data(r,c) = (r*8+c)*16` and feed 64 back-to-back samples -> 16 outputs `(2pr+1)*8 + 2pc+1`: first 9, last 63, each o_valid 2 cycles after its odd/odd input; `o_ch_end` pulses with the 16th output.
- **ReLU / saturation.** Set all inputs = -1000 -> 16 outputs = 0. Set all inputs = 5000 -> 16 outputs = 127 (312 saturated).
- **Multi-channel.** Run CO = 4 channels of the ramp with random `i_valid` gaps -> 4 `o_self_rst` pulses; `o_ch_idx` steps 0→3; `o_all_end` rises after the 4th `o_ch_end`; further `i_valid` produces no `o_valid`.
- **Soft reset.** Assert `user_reset` after 37 samples of channel 1 -> all outputs return to reset values; a fresh ramp reproduces the channel-0 result from index 0.
- **Early end.** Pulse `i_conv_end` after 20 samples -> `o_err` = 1 and stays set; the pooled sequence is unaffected.
- **Async reset.** Drop `global_rst_n` mid-cycle during an output -> `o_valid` falls immediately, without waiting for a clock edge.
